fetch_queue_unit: RTL and testbench

Parametrised instruction fetch unit with a direct-mapped I-cache and an instruction queue of configurable depth. It decouples fetch from dispatch using a valid/ready handshake. It sits between the memory controller and the decoder, consults the branch predictor for B-type instructions, and redirects on ROB flush. Unlike the previous fetcher, it keeps fetching while dispatch stalls, until the queue is full.

---
 rtl/fetch_queue_unit_if.sv | 37 +++
 rtl/fetch_queue_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_queue_unit.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_unit_if.sv
// Fetch unit bus bundle: memory controller, branch predictor, ROB flush and
// decoder-facing queue head. The unit side uses the master modport.
interface fetch_queue_unit_if #(
  parameter int BP_TAG_W = 8,
  parameter int IQ_DEPTH = 8
);
  localparam int CNT_W = $clog2(IQ_DEPTH) + 1;

  logic                out_mem_ce;
  logic [31:0]         out_mem_pc;
  logic                in_mem_ce;
  logic [31:0]         in_mem_instr;
  logic [BP_TAG_W-1:0] out_bp_tag;
  logic                in_bp_jump_ce;
  logic                in_flush;
  logic [31:0]         in_flush_pc;
  logic                out_valid;
  logic [31:0]         out_instr;
  logic [31:0]         out_pc;
  logic                out_jump_ce;
  logic                in_ready;
  logic [CNT_W-1:0]    out_iq_count;

  modport master (
    output out_mem_ce, out_mem_pc, out_bp_tag, out_valid, out_instr, out_pc,
           out_jump_ce, out_iq_count,
    input  in_mem_ce, in_mem_instr, in_bp_jump_ce, in_flush, in_flush_pc,
           in_ready
  );

  modport slave (
    input  out_mem_ce, out_mem_pc, out_bp_tag, out_valid, out_instr, out_pc,
           out_jump_ce, out_iq_count,
    output in_mem_ce, in_mem_instr, in_bp_jump_ce, in_flush, in_flush_pc,
           in_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: direct-mapped I-cache (one instruction per line),
// static JAL / predicted B-type redirection, and a circular instruction
// queue feeding the decoder. Define FETCH_ICACHE_EN to build the cache;
// without it every fetch goes to the memory controller.
module fetch_queue_unit #(
  parameter int          ICACHE_LINES = 256,
  parameter int          IQ_DEPTH     = 8,
  parameter int          BP_TAG_W     = 8,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input logic               clk,
  input logic               rst,
  input logic               rdy,
  fetch_queue_unit_if.master bus
);
  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t             state, state_n;
  logic [31:0]        pc;
  logic               mem_ce_q;
  logic [31:0]        mem_pc_q;
  logic [PTR_W-1:0]   head, tail;
  logic [CNT_W-1:0]   count;
  logic [31:0]        iq_instr [IQ_DEPTH];
  logic [31:0]        iq_pc    [IQ_DEPTH];
  logic               iq_jump  [IQ_DEPTH];

  logic               full, pop, push, req, hit;
  logic [31:0]        hit_instr, fetch_instr, pc_next;
  logic               jump_next;
  logic [31:0]        imm_j, imm_b;

`ifdef FETCH_ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] c_vld;
  logic [TAG_W-1:0]        c_tag  [ICACHE_LINES];
  logic [31:0]             c_data [ICACHE_LINES];
  logic [IDX_W-1:0]        idx;
  logic                    c_wr;

  assign idx       = pc[IDX_W+1:2];
  assign hit       = c_vld[idx] && (c_tag[idx] == pc[31:IDX_W+2]);
  assign hit_instr = c_data[idx];
  assign c_wr      = rdy && !bus.in_flush && (state == WAIT_MEM) && bus.in_mem_ce;

  // Line valid bits; cleared only by reset, a flush keeps the cache warm.
  always_ff @(posedge clk) begin
    if (rst)       c_vld      <= '0;
    else if (c_wr) c_vld[idx] <= 1'b1;
  end

  // Tag and instruction storage, filled from memory responses.
  always_ff @(posedge clk) begin
    if (c_wr) begin
      c_tag[idx]  <= pc[31:IDX_W+2];
      c_data[idx] <= bus.in_mem_instr;
    end
  end
`else
  assign hit       = 1'b0;
  assign hit_instr = '0;
`endif

  assign full = (count == CNT_W'(IQ_DEPTH));
  assign pop  = bus.out_valid && bus.in_ready;

  // Next-state and fetch decisions; space check uses the registered count,
  // so a pop in the same cycle does not unblock a full queue.
  always_comb begin
    state_n     = state;
    push        = 1'b0;
    req         = 1'b0;
    fetch_instr = bus.in_mem_instr;
    case (state)
      IDLE: begin
        if (!full) begin
          if (hit) begin
            push        = 1'b1;
            fetch_instr = hit_instr;
          end else begin
            req     = 1'b1;
            state_n = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (bus.in_mem_ce) begin
          push    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign imm_j = {{12{fetch_instr[31]}}, fetch_instr[19:12], fetch_instr[20],
                  fetch_instr[30:21], 1'b0};
  assign imm_b = {{20{fetch_instr[31]}}, fetch_instr[7], fetch_instr[30:25],
                  fetch_instr[11:8], 1'b0};

  // Next PC of the instruction being pushed; JALR falls through to pc+4.
  always_comb begin
    pc_next   = pc + 32'd4;
    jump_next = 1'b0;
    case (fetch_instr[6:0])
      7'b1101111: pc_next = pc + imm_j;
      7'b1100011: if (bus.in_bp_jump_ce) begin
        pc_next   = pc + imm_b;
        jump_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Fetch state register; flush returns to IDLE, rdy low freezes it.
  always_ff @(posedge clk) begin
    if (rst)                      state <= IDLE;
    else if (rdy && bus.in_flush) state <= IDLE;
    else if (rdy)                 state <= state_n;
  end

  // PC, memory request and queue pointers; flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      mem_ce_q <= 1'b0;
      mem_pc_q <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      mem_ce_q <= 1'b0;
      if (rdy) begin
        if (bus.in_flush) begin
          pc    <= bus.in_flush_pc;
          head  <= '0;
          tail  <= '0;
          count <= '0;
        end else begin
          if (req) begin
            mem_ce_q <= 1'b1;
            mem_pc_q <= pc;
          end
          if (push) begin
            tail <= tail + 1'b1;
            pc   <= pc_next;
          end
          if (pop) head <= head + 1'b1;
          count <= count + CNT_W'(push) - CNT_W'(pop);
        end
      end
    end
  end

  // Queue storage; contents past count are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (rdy && !rst && !bus.in_flush && push) begin
      iq_instr[tail] <= fetch_instr;
      iq_pc[tail]    <= pc;
      iq_jump[tail]  <= jump_next;
    end
  end

  assign bus.out_mem_ce   = mem_ce_q && rdy;
  assign bus.out_mem_pc   = mem_pc_q;
  assign bus.out_bp_tag   = pc[BP_TAG_W+1:2];
  assign bus.out_valid    = (count != '0);
  assign bus.out_instr    = bus.out_valid ? iq_instr[head] : '0;
  assign bus.out_pc       = bus.out_valid ? iq_pc[head]    : '0;
  assign bus.out_jump_ce  = bus.out_valid && iq_jump[head];
  assign bus.out_iq_count = count;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: a cycle table for the first pass over
// fresh addresses, then hand sequences for full queue, flush, prediction,
// push/pop balance, reset mid-miss and cache re-execution.
module tb_fetch_queue_unit;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam logic [31:0] JAL8  = 32'h0080006F; // jal +8
  localparam logic [31:0] BEQF  = 32'h00000463; // beq +8
  localparam logic [31:0] BEQB  = 32'hFE000CE3; // beq -8
  localparam logic [31:0] JALF  = 32'h1000006F; // jal +0x100
  localparam logic [31:0] JALB  = 32'hFFDFF06F; // jal -4

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int   checks = 0;
  int   failures = 0;

  fetch_queue_unit_if #(.BP_TAG_W(8), .IQ_DEPTH(8)) bus ();

  fetch_queue_unit #(.ICACHE_LINES(256), .IQ_DEPTH(8), .BP_TAG_W(8), .RESET_PC(32'h0))
    dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic rdy; logic mce; logic [31:0] mi; logic bp; logic fl; logic [31:0] fpc; logic rin;
    logic e_ce; logic [31:0] e_mpc; logic e_vld; logic [31:0] e_pc; logic [31:0] e_ins;
    logic e_jmp; int e_cnt;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic r, input logic m, input logic [31:0] mi,
                              input logic b, input logic f, input logic [31:0] fp,
                              input logic ri, input logic ce, input logic [31:0] mpc,
                              input logic v, input logic [31:0] p, input logic [31:0] ins,
                              input logic j, input int c);
    vec_t t;
    t.rdy = r; t.mce = m; t.mi = mi; t.bp = b; t.fl = f; t.fpc = fp; t.rin = ri;
    t.e_ce = ce; t.e_mpc = mpc; t.e_vld = v; t.e_pc = p; t.e_ins = ins; t.e_jmp = j;
    t.e_cnt = c;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_in(input logic m, input logic [31:0] mi, input logic b,
                        input logic f, input logic [31:0] fp, input logic ri);
    bus.in_mem_ce = m; bus.in_mem_instr = mi; bus.in_bp_jump_ce = b;
    bus.in_flush = f; bus.in_flush_pc = fp; bus.in_ready = ri;
  endtask

  initial begin
    int late;
    set_in(0, 0, 0, 0, 0, 0);

    // r   m  instr b  f  fpc       rin | ce mpc      v  pc       instr j  cnt
    tbl[0]  = mk(1, 0, 0,    0, 0, 0,        0,  1, 32'h0,   0, 32'h0,  0,    0, 0);
    tbl[1]  = mk(1, 0, 0,    0, 0, 0,        0,  0, 32'h0,   0, 32'h0,  0,    0, 0);
    tbl[2]  = mk(1, 0, 0,    0, 0, 0,        0,  0, 32'h0,   0, 32'h0,  0,    0, 0);
    tbl[3]  = mk(1, 1, NOP,  0, 0, 0,        0,  0, 32'h0,   1, 32'h0,  NOP,  0, 1);
    tbl[4]  = mk(1, 0, 0,    0, 0, 0,        0,  1, 32'h4,   1, 32'h0,  NOP,  0, 1);
    tbl[5]  = mk(1, 0, 0,    0, 0, 0,        1,  0, 32'h4,   0, 32'h0,  0,    0, 0);
    tbl[6]  = mk(1, 1, JAL8, 0, 0, 0,        0,  0, 32'h4,   1, 32'h4,  JAL8, 0, 1);
    tbl[7]  = mk(1, 0, 0,    0, 0, 0,        0,  1, 32'hC,   1, 32'h4,  JAL8, 0, 1);
    tbl[8]  = mk(1, 0, 0,    0, 0, 0,        0,  0, 32'hC,   1, 32'h4,  JAL8, 0, 1);
    tbl[9]  = mk(1, 1, BEQF, 1, 0, 0,        0,  0, 32'hC,   1, 32'h4,  JAL8, 0, 2);
    tbl[10] = mk(1, 0, 0,    0, 0, 0,        1,  1, 32'h14,  1, 32'hC,  BEQF, 1, 1);
    tbl[11] = mk(1, 0, 0,    0, 0, 0,        1,  0, 32'h14,  0, 32'h0,  0,    0, 0);
    tbl[12] = mk(1, 1, NOP,  0, 0, 0,        0,  0, 32'h14,  1, 32'h14, NOP,  0, 1);
    tbl[13] = mk(0, 1, NOP,  0, 1, 32'h200,  1,  0, 32'h14,  1, 32'h14, NOP,  0, 1);
    tbl[14] = mk(0, 1, NOP,  0, 1, 32'h200,  1,  0, 32'h14,  1, 32'h14, NOP,  0, 1);
    tbl[15] = mk(1, 0, 0,    0, 0, 0,        0,  1, 32'h18,  1, 32'h14, NOP,  0, 1);
    tbl[16] = mk(1, 1, NOP,  0, 1, 32'h100,  1,  0, 32'h18,  0, 32'h0,  0,    0, 0);
    tbl[17] = mk(1, 1, NOP,  0, 0, 0,        0,  1, 32'h100, 0, 32'h0,  0,    0, 0);

    // reset state
    @(negedge clk);
    step();
    chk("rst valid", 32'(bus.out_valid), 0);
    chk("rst mem_ce", 32'(bus.out_mem_ce), 0);
    chk("rst mem_pc", bus.out_mem_pc, 0);
    chk("rst count", 32'(bus.out_iq_count), 0);
    chk("rst pc", bus.out_pc, 0);
    chk("rst instr", bus.out_instr, 0);
    chk("rst jump", 32'(bus.out_jump_ce), 0);
    chk("rst bp_tag", 32'(bus.out_bp_tag), 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      rdy = tbl[i].rdy;
      set_in(tbl[i].mce, tbl[i].mi, tbl[i].bp, tbl[i].fl, tbl[i].fpc, tbl[i].rin);
      step();
      chk($sformatf("v%0d mem_ce", i), 32'(bus.out_mem_ce), 32'(tbl[i].e_ce));
      chk($sformatf("v%0d mem_pc", i), bus.out_mem_pc, tbl[i].e_mpc);
      chk($sformatf("v%0d valid", i), 32'(bus.out_valid), 32'(tbl[i].e_vld));
      chk($sformatf("v%0d pc", i), bus.out_pc, tbl[i].e_pc);
      chk($sformatf("v%0d instr", i), bus.out_instr, tbl[i].e_ins);
      chk($sformatf("v%0d jump", i), 32'(bus.out_jump_ce), 32'(tbl[i].e_jmp));
      chk($sformatf("v%0d count", i), 32'(bus.out_iq_count), tbl[i].e_cnt);
    end

    // fill the queue with in_ready low; memory answers one cycle after each request
    rdy = 1'b1;
    set_in(0, NOP, 0, 0, 0, 0);
    late = 0;
    for (int k = 0; k < 40; k++) begin
      bus.in_mem_ce = bus.out_mem_ce;
      step();
      if (k >= 30 && bus.out_mem_ce) late++;
    end
    bus.in_mem_ce = 1'b0;
    chk("full count", 32'(bus.out_iq_count), 8);
    chk("full head pc", bus.out_pc, 32'h100);
    chk("no fetch while full", late, 0);

    // first pop does not unblock the fetch in the same cycle
    bus.in_ready = 1'b1;
    step();
    chk("pop1 count", 32'(bus.out_iq_count), 7);
    chk("pop1 mem_ce", 32'(bus.out_mem_ce), 0);
    bus.in_ready = 1'b0;
    step();
    chk("resume mem_ce", 32'(bus.out_mem_ce), 1);
    chk("resume mem_pc", bus.out_mem_pc, 32'h120);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("drain%0d pc", k), bus.out_pc, 32'h104 + 32'(4 * k));
      bus.in_ready = 1'b1;
      step();
    end
    chk("drain count", 32'(bus.out_iq_count), 5);
    chk("drain head", bus.out_pc, 32'h10C);

    // flush in WAIT_MEM with count 5, concurrent response and pop are dropped
    set_in(1, NOP, 0, 1, 32'h300, 1);
    step();
    chk("flush count", 32'(bus.out_iq_count), 0);
    chk("flush valid", 32'(bus.out_valid), 0);
    chk("flush mem_ce", 32'(bus.out_mem_ce), 0);
    set_in(1, NOP, 0, 0, 0, 0);
    step();
    chk("stale count", 32'(bus.out_iq_count), 0);
    chk("post-flush mem_ce", 32'(bus.out_mem_ce), 1);
    chk("post-flush mem_pc", bus.out_mem_pc, 32'h300);

    // backward predicted branch
    set_in(1, BEQB, 1, 0, 0, 0);
    step();
    chk("beq pc", bus.out_pc, 32'h300);
    chk("beq jump", 32'(bus.out_jump_ce), 1);
    chk("beq instr", bus.out_instr, BEQB);
    chk("bp_tag", 32'(bus.out_bp_tag), 32'hBE);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk("beq target", bus.out_mem_pc, 32'h2F8);
    set_in(1, JALF, 0, 0, 0, 0);
    step();
    chk("jalf count", 32'(bus.out_iq_count), 2);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk("jalf target", bus.out_mem_pc, 32'h3F8);
    set_in(1, NOP, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk("pre-pp count", 32'(bus.out_iq_count), 3);
    chk("pre-pp mem_pc", bus.out_mem_pc, 32'h3FC);

    // simultaneous push and pop at count 3
    set_in(1, NOP, 0, 0, 0, 1);
    step();
    chk("pushpop count", 32'(bus.out_iq_count), 3);
    chk("pushpop head", bus.out_pc, 32'h2F8);
    chk("pushpop instr", bus.out_instr, JALF);
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk("req 0x400", bus.out_mem_pc, 32'h400);

    // reset during a miss drops the response
    rst = 1'b1;
    bus.in_mem_ce = 1'b1;
    step();
    rst = 1'b0;
    bus.in_mem_ce = 1'b0;
    chk("rstmiss count", 32'(bus.out_iq_count), 0);
    chk("rstmiss mem_ce", 32'(bus.out_mem_ce), 0);
    chk("rstmiss mem_pc", bus.out_mem_pc, 0);
    step();
    chk("rstmiss refetch", 32'(bus.out_mem_ce), 1);
    chk("rstmiss refetch pc", bus.out_mem_pc, 0);

    // tiny loop 0x0: nop, 0x4: jal -4
    set_in(1, NOP, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0);
    step();
    chk("loop req4", bus.out_mem_pc, 32'h4);
    set_in(1, JALB, 0, 0, 0, 0);
    step();
    chk("loop count", 32'(bus.out_iq_count), 2);
    set_in(0, 0, 0, 0, 0, 1);
`ifdef FETCH_ICACHE_EN
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("hit%0d mem_ce", k), 32'(bus.out_mem_ce), 0);
      chk($sformatf("hit%0d count", k), 32'(bus.out_iq_count), 2);
      chk($sformatf("hit%0d head", k), bus.out_pc, (k % 2 == 1) ? 32'h4 : 32'h0);
    end
`else
    step();
    chk("nocache mem_ce", 32'(bus.out_mem_ce), 1);
    chk("nocache mem_pc", bus.out_mem_pc, 32'h0);
    chk("nocache count", 32'(bus.out_iq_count), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
